instr_encoder: RTL
==================

# instr_encoder

Program loader that assembles 32-bit RV32I instruction words from decoded fields and writes them sequentially into instruction memory. It performs the inverse of the core's immediate extension: it packs a 32-bit signed immediate into the I/S/B/J bit layouts, using the same 3-bit format codes. It sits between a host/debug front end and the instruction-memory write port, and is used for boot loading and test-program injection.

## Interface
- `ADDR_W`, 8: word-index width; memory depth DEPTH = 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a load session; honoured only in IDLE.
- `in_valid` input 1: field beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_last` input 1: accepted beat is the final beat of the session.
- `fmt` input 3: 000 I, 001 S, 010 B, 011 J, 100 R; 101–111 illegal.
- `opcode` input 7; `rd`, `rs1`, `rs2` input 5 each; `funct3` input 3; `funct7` input 7.
- `imm` input 32: signed immediate value (byte offset for B/J).
- `imem_we` output 1: memory write strobe.
- `imem_addr` output 32: byte address.
- `imem_wdata` output 32: encoded instruction.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse at session end.
- `full` output 1: DEPTH words written in this session.
- `err` output 1: sticky flag, set on any rejected beat.
- `err_cnt` output 8: count of rejected beats, saturates at 255.
- `word_cnt` output ADDR_W+1: words written in this session.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → DONE on an accepted beat that has `in_last` set, or on an accepted beat that makes `word_cnt` reach DEPTH.
  - DONE → IDLE unconditionally after one cycle.
- `start` clears `word_cnt`, `err`, `err_cnt` and `full`. `start` is ignored in LOAD and DONE.
- `in_ready` = (state == LOAD) && !full.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `imm` is ignored.
- A rejected beat is still accepted (handshake completes) but is not written. A rejected beat sets `err`, increments `err_cnt` and does not advance `word_cnt`. A rejected beat that has `in_last` set still ends the session.
- Illegal `fmt` is always rejected.
- Write address: `imem_addr` = BASE_ADDR + 4·word_cnt, using the value of `word_cnt` before its increment.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `busy`, `done`, `full`, `err` = 0; `imem_addr`, `imem_wdata`, `err_cnt`, `word_cnt` = 0.
- Latency: a beat accepted in cycle N produces a registered `imem_we`/`imem_addr`/`imem_wdata` in cycle N+1. `imem_we` is high for exactly one cycle per written word.
- The memory port has no backpressure.
- The final beat's write occurs in the same cycle as DONE, and `done` is high in that cycle.
- `full` rises in the cycle after the DEPTH-th write is accepted and holds until the next `start` or reset. After `full`, the session ends with no further `in_ready`.
- `err_cnt` holds at 255 once it reaches 255.
- Asserting `rst_n` low mid-session returns all outputs to their reset values immediately. A pending write is dropped.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined:
  - I/S beats are rejected unless `imm` lies in −2048..2047.
  - B beats are rejected unless `imm` lies in −4096..4094 and imm[0] = 0.
  - J beats are rejected unless `imm` lies in −1048576..1048574 and imm[0] = 0.
- `INSTR_ENC_RANGE_CHECK_EN` undefined: immediates are truncated silently to the bits used by the format. Only illegal `fmt` sets `err`.

## Structure
- Shared package holds: the format codes (shared with the core's immediate extender), the RV32I opcode constants, and the FSM state enum.
- One combinational sub-module, `instr_pack`: takes the fields plus `fmt` and produces the encoded word and a reject flag. The range check lives here, under the macro.
- The top level holds the FSM, counters and output registers.

## Test plan
- I, opcode 0010011, rd 1, rs1 0, funct3 0, imm 5 → write 0x00500093 at BASE_ADDR.
- S, opcode 0100011, rs1 1, rs2 2, funct3 010, imm 8 → 0x0020A423. B, opcode 1100011, rs1/rs2 0, imm −4 → 0xFE000EE3 at BASE_ADDR+4.
- J, opcode 1101111, rd 1, imm 2048 → 0x001000EF. Same beat with `in_last` → `done` high for one cycle in the write cycle, then IDLE.
- With macro defined: I, imm 2048 → no `imem_we`, `err` = 1, `err_cnt` = 1, `word_cnt` unchanged. Without macro: same beat writes imm[11:0] = 0x800.
- ADDR_W = 2, five beats offered, none with `in_last` → four writes at +0/+4/+8/+12, `full` = 1, `in_ready` low, fifth beat never accepted, `done` pulses.
- `rst_n` low after two accepted beats → all outputs zero immediately; `start` then restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I program loader: format codes, opcode constants
// and the loader FSM state encoding.
package instr_encoder_pkg;

    // Format codes are shared with the core's immediate extender.
    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_R = 3'b100;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic fmt_legal(input logic [2:0] f);
        return (f <= FMT_R);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I word packer: places register fields and the immediate into
// the I/S/B/J/R layouts. Immediate range checking is built only with INSTR_ENC_RANGE_CHECK_EN.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_reject
);

    logic w_range_bad;

    always_comb begin
        o_word = 32'h0;
        case (i_fmt)
            FMT_I: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
            FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            default: o_word = 32'h0;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic signed [31:0] w_simm;
    assign w_simm = i_imm;

    // B/J offsets must be halfword aligned since bit 0 is not encoded.
    always_comb begin
        w_range_bad = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: w_range_bad = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
            FMT_B: w_range_bad = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || i_imm[0];
            FMT_J: w_range_bad = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || i_imm[0];
            default: w_range_bad = 1'b0;
        endcase
    end
`else
    logic w_unused_imm;
    assign w_unused_imm = ^i_imm[31:21];
    assign w_range_bad  = 1'b0;
`endif

    assign o_reject = !fmt_legal(i_fmt) || w_range_bad;

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded field beats, packs them into RV32I words and writes
// them sequentially to instruction memory. Optional macro: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e          r_state;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_done;
    logic            r_full;
    logic            r_err;
    logic [7:0]      r_err_cnt;
    logic [ADDR_W:0] r_word_cnt;

    logic [31:0]     w_word;
    logic            w_reject;
    logic            w_accept;
    logic            w_write;
    logic [ADDR_W:0] w_cnt_inc;
    logic            w_hit_full;
    logic [31:0]     w_addr;

    instr_pack u_pack (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_reject (w_reject)
    );

    assign in_ready   = (r_state == ST_LOAD) && !r_full;
    assign w_accept   = in_valid && in_ready;
    assign w_write    = w_accept && !w_reject;
    assign w_cnt_inc  = r_word_cnt + CNT_ONE;
    assign w_hit_full = w_write && (w_cnt_inc == DEPTH_CNT);
    // Address uses the pre-increment count.
    assign w_addr     = BASE_ADDR + {{(32-ADDR_W-3){1'b0}}, r_word_cnt, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'h0;
            r_word_cnt <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_word_cnt <= '0;
                        r_err      <= 1'b0;
                        r_err_cnt  <= 8'h0;
                        r_full     <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_write) begin
                            r_we       <= 1'b1;
                            r_addr     <= w_addr;
                            r_wdata    <= w_word;
                            r_word_cnt <= w_cnt_inc;
                            if (w_hit_full) r_full <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        // Done is registered alongside the final write so both land together.
                        if (in_last || w_hit_full) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign full       = r_full;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign word_cnt   = r_word_cnt;

endmodule
